// File: rtl/fifo_bulk_rd_ctrl.sv
// Read-side sequencer for the dual-clock FIFO. It pops fall-through data in
// fixed-length bursts and flushes residue or aborts starved bursts on a watchdog.
module fifo_bulk_rd_ctrl #(
  parameter int DSIZE          = 8,
  parameter int BULK_NUMBER    = 10,
  parameter int WATCHDOG_LIMIT = 100,
  parameter int CNT_W          = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             enable,
  input  logic             rempty,
  input  logic             arempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             rinc_mem,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             flush_pulse,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] burst_count
);

  localparam int BW = $clog2(BULK_NUMBER);
  localparam int WW = $clog2(WATCHDOG_LIMIT);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BULK_NUMBER - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(WATCHDOG_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    beat_cnt, beat_nxt;
  logic [WW-1:0]    wd_cnt, wd_nxt;
  logic [WW-1:0]    stall_cnt, stall_nxt;
  logic [CNT_W-1:0] bcnt_nxt;
  logic             flush_nxt, stall_to_nxt;
  logic             hs;

  // Fall-through FIFO: data is already on rdata, so a pop is just the handshake.
  assign out_valid = (state == BURST || state == FLUSH) && !rempty;
  assign out_data  = rdata;
  assign hs        = out_valid && out_ready;
  assign rinc      = hs;
  assign rinc_mem  = hs;
  assign out_last  = out_valid && ((state == BURST && beat_cnt == BEAT_LAST) || state == FLUSH);
  assign busy      = (state != IDLE);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      wd_cnt        <= '0;
      stall_cnt     <= '0;
      burst_count   <= '0;
      flush_pulse   <= 1'b0;
      stall_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      beat_cnt      <= beat_nxt;
      wd_cnt        <= wd_nxt;
      stall_cnt     <= stall_nxt;
      burst_count   <= bcnt_nxt;
      flush_pulse   <= flush_nxt;
      stall_timeout <= stall_to_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat_cnt;
    wd_nxt       = wd_cnt;
    stall_nxt    = stall_cnt;
    bcnt_nxt     = burst_count;
    flush_nxt    = 1'b0;
    stall_to_nxt = 1'b0;
    case (state)
      IDLE: begin
        // A full burst worth of data wins over the residue watchdog.
        if (enable && !arempty) begin
          state_nxt = BURST;
          beat_nxt  = '0;
          stall_nxt = '0;
          wd_nxt    = '0;
        end else if (enable && !rempty) begin
          if (wd_cnt == WD_LAST) begin
            state_nxt = FLUSH;
            flush_nxt = 1'b1;
            wd_nxt    = '0;
          end else begin
            wd_nxt = wd_cnt + 1'b1;
          end
        end else begin
          wd_nxt = '0;
        end
      end
      BURST: begin
        if (hs) begin
          beat_nxt  = beat_cnt + 1'b1;
          stall_nxt = '0;
          if (beat_cnt == BEAT_LAST) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
            bcnt_nxt  = burst_count + 1'b1;
          end
        end else if (rempty) begin
          // Only starvation counts; backpressure with data present holds.
          if (stall_cnt == WD_LAST) begin
            state_nxt    = IDLE;
            stall_to_nxt = 1'b1;
            stall_nxt    = '0;
          end else begin
            stall_nxt = stall_cnt + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (rempty) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_bulk_rd_ctrl.sv
// Directed bench for fifo_bulk_rd_ctrl; a queue stands in for the FIFO and
// words are written as an incrementing sequence so order can be checked.
module tb_fifo_bulk_rd_ctrl;
  localparam int DSIZE = 8;
  localparam int CNT_W = 16;

  logic             rclk = 1'b0;
  logic             rrst, enable, rempty, arempty, out_ready;
  logic [DSIZE-1:0] rdata;
  logic             rinc, rinc_mem, out_valid, out_last, busy, flush_pulse, stall_timeout;
  logic [DSIZE-1:0] out_data;
  logic [CNT_W-1:0] burst_count;

  fifo_bulk_rd_ctrl #(.DSIZE(DSIZE), .BULK_NUMBER(10), .WATCHDOG_LIMIT(100), .CNT_W(CNT_W)) dut (
    .rclk(rclk), .rrst(rrst), .enable(enable), .rempty(rempty), .arempty(arempty),
    .rdata(rdata), .rinc(rinc), .rinc_mem(rinc_mem), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .busy(busy),
    .flush_pulse(flush_pulse), .stall_timeout(stall_timeout), .burst_count(burst_count)
  );

  always #5 rclk = ~rclk;

  logic [DSIZE-1:0] q[$];
  logic [DSIZE-1:0] wr_seq, exp_rd;
  int               ae_thr;
  int               checks, errors;
  int               cyc, hs_cnt, last_cnt, fl_cnt, st_cnt, first_fl, first_val, first_st, last_hs;
  int               data_bad, proto_bad;
  logic [63:0]      last_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_fifo();
    rempty  = (q.size() == 0);
    arempty = (q.size() < ae_thr);
    rdata   = (q.size() == 0) ? '0 : q[0];
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back(wr_seq);
      wr_seq++;
    end
    upd_fifo();
  endtask

  task automatic clr();
    cyc = 0; hs_cnt = 0; last_cnt = 0; fl_cnt = 0; st_cnt = 0;
    first_fl = 0; first_val = 0; first_st = 0; last_hs = 0; last_mask = '0;
  endtask

  // Sample one cycle mid-period, then advance past the edge and model the pop.
  task automatic tick();
    logic pop;
    #1;
    cyc++;
    pop = rinc;
    if (rinc && rempty) proto_bad++;
    if (rinc_mem !== rinc) proto_bad++;
    if (out_valid && rempty) proto_bad++;
    if (out_valid && first_val == 0) first_val = cyc;
    if (flush_pulse) begin
      fl_cnt++;
      if (first_fl == 0) first_fl = cyc;
    end
    if (stall_timeout) begin
      st_cnt++;
      if (first_st == 0) first_st = cyc;
    end
    if (rinc) begin
      if (out_data !== exp_rd) data_bad++;
      exp_rd++;
      if (out_last) begin
        last_cnt++;
        if (hs_cnt < 64) last_mask[hs_cnt] = 1'b1;
      end
      hs_cnt++;
      last_hs = cyc;
    end
    @(posedge rclk);
    #1;
    if (pop) void'(q.pop_front());
    upd_fifo();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks = 0; errors = 0; data_bad = 0; proto_bad = 0;
    wr_seq = '0; exp_rd = '0; ae_thr = 10;
    rrst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    upd_fifo();
    clr();
    ticks(3);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_bcnt", burst_count, '0);
    chk("rst_flush", flush_pulse, 1'b0);
    chk("rst_stall", stall_timeout, 1'b0);
    rrst = 1'b0;

    // Two full bursts then a five-word flush.
    clr();
    push(25); enable = 1'b1; out_ready = 1'b1;
    ticks(300);
    chk("t1_hs", hs_cnt, 25);
    chk("t1_last_mask", last_mask, 64'h1F8_0200);
    chk("t1_flush_cnt", fl_cnt, 1);
    chk("t1_bcnt", burst_count, 2);
    chk("t1_idle", busy, 1'b0);

    // Residue below threshold waits out the watchdog.
    clr();
    push(3);
    ticks(200);
    chk("t2_first_flush", first_fl, 101);
    chk("t2_first_valid", first_val, 101);
    chk("t2_hs", hs_cnt, 3);
    chk("t2_last", last_cnt, 3);
    chk("t2_bcnt", burst_count, 2);

    // Toggling backpressure, then a long stretch of out_ready=0.
    clr();
    push(12);
    for (int i = 0; i < 60; i++) begin
      out_ready = i[0];
      tick();
    end
    chk("t3_hs", hs_cnt, 10);
    chk("t3_last_mask", last_mask, 64'h200);
    chk("t3_bcnt", burst_count, 3);
    clr();
    out_ready = 1'b0;
    push(8);
    ticks(200);
    chk("t3_bp_busy", busy, 1'b1);
    chk("t3_bp_hs", hs_cnt, 0);
    chk("t3_bp_stall", st_cnt, 0);
    out_ready = 1'b1;
    ticks(20);
    chk("t3_bp_done", hs_cnt, 10);
    chk("t3_bp_bcnt", burst_count, 4);

    // Writer stops after 4 words of a burst.
    clr();
    ae_thr = 4;
    push(4);
    ticks(150);
    ae_thr = 10;
    chk("t4_hs", hs_cnt, 4);
    chk("t4_stall_cnt", st_cnt, 1);
    chk("t4_stall_gap", first_st - last_hs, 101);
    chk("t4_last", last_cnt, 0);
    chk("t4_bcnt", burst_count, 4);
    chk("t4_idle", busy, 1'b0);

    // Reset after beat 5 of a burst.
    clr();
    push(10);
    for (int i = 0; i < 50 && hs_cnt < 5; i++) tick();
    chk("t5_beats", hs_cnt, 5);
    rrst = 1'b1; out_ready = 1'b0;
    tick();
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_bcnt", burst_count, '0);
    chk("t5_beat_cnt", dut.beat_cnt, '0);
    chk("t5_stall_cnt", dut.stall_cnt, '0);
    chk("t5_left", q.size(), 5);
    rrst = 1'b0; out_ready = 1'b1;
    clr();
    ticks(130);
    chk("t5_flushed", hs_cnt, 5);
    chk("t5_last", last_cnt, 0 + 5);

    // enable low holds everything off regardless of fill.
    clr();
    enable = 1'b0;
    push(16);
    ticks(150);
    chk("t6_hs", hs_cnt, 0);
    chk("t6_wd", dut.wd_cnt, '0);
    chk("t6_flush", fl_cnt, 0);
    enable = 1'b1;
    tick();
    #1;
    chk("t6_start_busy", busy, 1'b1);
    chk("t6_start_valid", out_valid, 1'b1);
    ticks(20);
    chk("t6_hs_after", hs_cnt, 10);
    chk("t6_bcnt", burst_count, 1);

    chk("data_order", data_bad, 0);
    chk("protocol", proto_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_bulk_rd_ctrl.md
Name: fifo_bulk_rd_ctrl

Overview:
- Read-side sequencer for the dual-clock FIFO. Lives entirely in the FIFO read clock domain.
- Drives the FIFO `rinc` / `rinc_mem` strobes and forwards fall-through `rdata` to a downstream valid/ready consumer as fixed-length bursts of BULK_NUMBER words.
- When data lingers below burst threshold for WATCHDOG_LIMIT cycles, it flushes the residue as single-word bursts.
- It also times out bursts that starve mid-transfer.

Parameters:
- DSIZE, 8, data word width; matches FIFO DSIZE.
- BULK_NUMBER, 10, words per normal burst; legal range ≥2.
- WATCHDOG_LIMIT, 100, cycles of idle-with-data before flush, and cycles of starvation before burst abort; legal range ≥2.
- CNT_W, 16, width of burst_count.

Ports:
- rclk, input, 1, read-domain clock.
- rrst, input, 1, synchronous active-high reset.
- enable, input, 1, permits starting new bursts or flushes; sampled only in IDLE.
- rempty, input, 1, FIFO empty flag.
- arempty, input, 1, FIFO almost-empty flag.
- rdata, input, DSIZE, FIFO fall-through read data; valid whenever rempty=0.
- rinc, output, 1, FIFO read-pointer advance.
- rinc_mem, output, 1, FIFO memory read enable.
- out_valid, output, 1, downstream data valid.
- out_data, output, DSIZE, downstream data.
- out_last, output, 1, last word of current burst.
- out_ready, input, 1, downstream accept.
- busy, output, 1, state ≠ IDLE.
- flush_pulse, output, 1, one-cycle pulse when FLUSH is entered.
- stall_timeout, output, 1, one-cycle pulse on burst abort.
- burst_count, output, CNT_W, completed full bursts; wraps modulo 2^CNT_W.

Behaviour:
- Clocking and reset:
  - All state updates on posedge rclk.
  - While rrst=1: state=IDLE, beat_cnt=0, wd_cnt=0, stall_cnt=0, burst_count=0, flush_pulse=0, stall_timeout=0.
  - A reset mid-burst abandons the burst immediately. No out_last is produced. FIFO contents are untouched.
- Combinational outputs:
  - out_valid = (state==BURST || state==FLUSH) && !rempty.
  - out_data = rdata.
  - rinc = rinc_mem = out_valid && out_ready. A handshake is a cycle with rinc=1; it pops exactly one word, zero added latency.
  - out_last = out_valid && ((state==BURST && beat_cnt==BULK_NUMBER-1) || state==FLUSH).
  - No rinc is ever issued while rempty=1.
- IDLE:
  - If enable && !arempty: go to BURST; beat_cnt=0, stall_cnt=0, wd_cnt=0.
  - Else if enable && !rempty: wd_cnt++. When wd_cnt==WATCHDOG_LIMIT-1, go to FLUSH, assert flush_pulse next cycle, and clear wd_cnt.
  - Else (rempty or !enable): wd_cnt=0.
  - The !arempty start check has priority over the watchdog in the same cycle.
- BURST:
  - On handshake: beat_cnt++ and stall_cnt=0.
  - On the handshake with beat_cnt==BULK_NUMBER-1: go to IDLE and increment burst_count.
  - Cycles with rempty=1 increment stall_cnt. Backpressure cycles (out_ready=0 with data present) do not count and hold stall_cnt.
  - When stall_cnt==WATCHDOG_LIMIT-1 while rempty=1: go to IDLE and pulse stall_timeout for 1 cycle. The burst is truncated, with no out_last and no burst_count increment.
  - enable is ignored inside BURST; the burst always completes or times out.
- FLUSH:
  - Every handshake is a single-word burst with out_last=1; burst_count is not incremented.
  - Exits to IDLE on the first cycle rempty=1 is sampled.
  - The new-data arrival threshold (arempty deasserting) is not re-evaluated until IDLE.
- Simultaneous events:
  - A handshake on the final beat in the same cycle as the stall threshold cannot occur, because stall requires rempty.
  - A burst_count wrap is silent.

Test Plan:
- Reset, then 25 words written, enable=1, out_ready=1: two bursts of 10 with out_last on beats 10 and 20; burst_count=2. The 5 residual words flush after 100 idle cycles: flush_pulse=1 once, then 5 single-word outputs each with out_last=1, then IDLE.
- 3 words written, enable=1: no out_valid for 99 cycles. On cycle 100, flush_pulse is asserted, followed by 3 words each with out_last=1; burst_count stays 0.
- Burst started with 12 words, out_ready toggling 1/0 every cycle: 10 words delivered in order with no drops or duplicates, and rinc count = 10. stall_timeout never asserts even with long out_ready=0 stretches (e.g. 200 cycles).
- Burst started, writer stops after 4 words: after beat 4, 100 empty cycles produce stall_timeout=1 for one cycle, state returns to IDLE, and burst_count is unchanged.
- Reset asserted on beat 5 of a burst: next cycle busy=0, out_valid=0, all counters=0, and the remaining FIFO words stay readable.
- enable=0 with the FIFO full: rinc stays 0 and wd_cnt stays 0. Raising enable starts a burst on the next cycle.
